// File: rtl/threshold_bram_reader.sv
`default_nettype none
// ============================================================================
// Module   : threshold_bram_reader
// Brief    : Looks up the Tanimoto threshold for each incoming popcount in the
//            BRAM (port B) and streams {threshold, popcount} out through a
//            credit-controlled FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module threshold_bram_reader #(
  parameter int VECTOR_WIDTH = 920,
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [CNT_WIDTH-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [CNT_WIDTH-1:0]   bram_addr,
  output logic                   bram_en,
  input  logic [CNT_WIDTH-1:0]   bram_rddata,
  output logic [2*CNT_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser
);

  localparam logic [CNT_WIDTH-1:0] c_MAX_ADDR = CNT_WIDTH'(VECTOR_WIDTH);
  localparam int                   c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                   c_OCC_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_OCC_W-1:0]   c_DEPTH    = c_OCC_W'(FIFO_DEPTH);
  localparam logic [c_PTR_W-1:0]   c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] pop;
    logic                 last;
    logic                 err;
  } side_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] thr;
    side_t                side;
  } entry_t;

  logic [c_OCC_W-1:0]    r_occ;
  logic [c_OCC_W-1:0]    r_count;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [RD_LATENCY-1:0] r_sr_valid;
  side_t                 r_sr_side [RD_LATENCY];
  entry_t                r_mem     [FIFO_DEPTH];

  logic   w_accept;
  logic   w_err;
  logic   w_wr;
  logic   w_pop;
  entry_t w_head;

  // Gating with aresetn keeps ready low during reset and high on the first
  // cycle after release, without any dependence on m_axis_tready.
  assign s_axis_tready = aresetn & (r_occ < c_DEPTH);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_err         = (s_axis_tdata > c_MAX_ADDR);
  assign bram_en       = w_accept;
  assign bram_addr     = w_err ? c_MAX_ADDR : s_axis_tdata;

  assign w_wr          = r_sr_valid[RD_LATENCY-1];
  assign w_head        = r_mem[r_rd_ptr];
  assign m_axis_tvalid = (r_count != '0);
  assign w_pop         = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? {w_head.thr, w_head.side.pop} : '0;
  assign m_axis_tlast  = m_axis_tvalid & w_head.side.last;
  assign m_axis_tuser  = m_axis_tvalid & w_head.side.err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_occ      <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sr_valid <= '0;
    end else begin
      r_sr_valid[0] <= w_accept;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_sr_valid[i] <= r_sr_valid[i-1];
      end

      if (w_accept && !w_pop) begin
        r_occ <= r_occ + c_OCC_W'(1);
      end else if (!w_accept && w_pop) begin
        r_occ <= r_occ - c_OCC_W'(1);
      end

      if (w_wr && !w_pop) begin
        r_count <= r_count + c_OCC_W'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - c_OCC_W'(1);
      end

      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
    end
  end

  // Payload storage needs no reset: only the valid bits and pointers matter.
  always_ff @(posedge aclk) begin
    r_sr_side[0] <= '{pop: s_axis_tdata, last: s_axis_tlast, err: w_err};
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_sr_side[i] <= r_sr_side[i-1];
    end
    if (w_wr) begin
      r_mem[r_wr_ptr] <= '{thr: bram_rddata, side: r_sr_side[RD_LATENCY-1]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_threshold_bram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_threshold_bram_reader
// Brief    : Directed self-checking bench with a 1-cycle port-B BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_threshold_bram_reader;

  localparam int CW = 10;

  typedef struct {
    logic [CW-1:0] data;
    logic          last;
  } item_t;

  typedef struct {
    logic [2*CW-1:0] data;
    logic            last;
    logic            user;
    int              cyc;
  } beat_t;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [CW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic            s_tlast = 1'b0;
  logic [CW-1:0]   bram_addr;
  logic            bram_en;
  logic [CW-1:0]   bram_rddata = '0;
  logic [2*CW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic            m_tuser;

  logic [CW-1:0]   bram [1024];
  int              cyc = 0;
  int              n_assert = 0;
  int              n_fail = 0;
  int              drops = 0;
  int              en_bad = 0;
  int              stab_bad = 0;
  item_t           src_q[$];
  beat_t           beats[$];
  logic [CW-1:0]   addr_q[$];
  int              acc_cyc_q[$];

  logic            stall_prev = 1'b0;
  logic [2*CW-1:0] prev_data;
  logic            prev_last;
  logic            prev_user;

  threshold_bram_reader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .bram_addr     (bram_addr),
    .bram_en       (bram_en),
    .bram_rddata   (bram_rddata),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (bram_en) bram_rddata <= bram[bram_addr];
  end

  always @(negedge aclk) begin
    if (m_tvalid && m_tready) begin
      beats.push_back('{data: m_tdata, last: m_tlast, user: m_tuser, cyc: cyc});
    end
    if (stall_prev && aresetn &&
        (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last || m_tuser !== prev_user)) begin
      stab_bad++;
    end
    stall_prev = aresetn && m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    prev_user  = m_tuser;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_logs();
    beats.delete();
    addr_q.delete();
    acc_cyc_q.delete();
    drops    = 0;
    en_bad   = 0;
    stab_bad = 0;
  endtask

  task automatic push_item(input int value, input logic last);
    item_t it;
    it.data = CW'(value);
    it.last = last;
    src_q.push_back(it);
  endtask

  // mode 0: sink always ready, 1: sink stalled, 2: low 2 / high 6 pattern
  task automatic run(input int ncyc, input int mode);
    logic acc;
    for (int c = 0; c < ncyc; c++) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ((cyc % 8) >= 2);
      endcase
      if (src_q.size() > 0) begin
        s_tdata  = src_q[0].data;
        s_tlast  = src_q[0].last;
        s_tvalid = 1'b1;
      end else begin
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
      end
      #1;
      acc = s_tvalid && s_tready;
      if (s_tvalid && !s_tready) drops++;
      if (acc !== bram_en) en_bad++;
      if (acc) begin
        addr_q.push_back(bram_addr);
        acc_cyc_q.push_back(cyc);
      end
      tick();
      if (acc) void'(src_q.pop_front());
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = (i <= 920) ? CW'(i) : '0;

    // Reset state, with a valid input pending that must not be taken
    s_tvalid = 1'b1;
    s_tdata  = CW'(5);
    repeat (3) tick();
    check("rst_s_tready", 32'(s_tready), 0);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_m_tlast",  32'(m_tlast),  0);
    check("rst_m_tuser",  32'(m_tuser),  0);
    check("rst_m_tdata",  32'(m_tdata),  0);
    check("rst_bram_en",  32'(bram_en),  0);
    s_tvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    #1;
    check("post_rst_s_tready", 32'(s_tready), 1);
    tick();

    // Single item
    clear_logs();
    push_item(37, 1'b0);
    run(8, 0);
    check("single_addr",  (addr_q.size() > 0) ? 32'(addr_q[0]) : 32'hFFFF, 37);
    check("single_beats", beats.size(), 1);
    if (beats.size() > 0 && acc_cyc_q.size() > 0) begin
      check("single_tdata",   32'(beats[0].data), {12'd0, 10'd37, 10'd37});
      check("single_tuser",   32'(beats[0].user), 0);
      check("single_tlast",   32'(beats[0].last), 0);
      check("single_latency", beats[0].cyc - acc_cyc_q[0], 2);
    end

    // Back-to-back 1..16
    clear_logs();
    for (int i = 1; i <= 16; i++) push_item(i, 1'b0);
    run(24, 0);
    check("b2b_drops",  drops, 0);
    check("b2b_en",     en_bad, 0);
    check("b2b_beats",  beats.size(), 16);
    if (beats.size() == 16) begin
      for (int j = 0; j < 16; j++) begin
        check($sformatf("b2b_tdata_%0d", j + 1), 32'(beats[j].data), (32'(j + 1) << CW) | 32'(j + 1));
        check($sformatf("b2b_cycle_%0d", j + 1), beats[j].cyc - beats[0].cyc, j);
      end
    end

    // Backpressure: 12 stalled cycles with 8 items offered
    clear_logs();
    for (int i = 0; i < 8; i++) push_item(100 + i, 1'b0);
    run(12, 1);
    check("bp_accepted",  8 - src_q.size(), 4);
    check("bp_s_tready",  32'(s_tready), 0);
    check("bp_no_output", beats.size(), 0);
    check("bp_stable",    stab_bad, 0);
    src_q.delete();
    run(10, 0);
    check("bp_beats", beats.size(), 4);
    if (beats.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("bp_tdata_%0d", j), 32'(beats[j].data), (32'(100 + j) << CW) | 32'(100 + j));
      end
    end

    // Range saturation
    clear_logs();
    push_item(920, 1'b0);
    push_item(921, 1'b0);
    push_item(1023, 1'b0);
    run(8, 0);
    check("rng_accepts", addr_q.size(), 3);
    check("rng_beats",   beats.size(), 3);
    if (addr_q.size() == 3 && beats.size() == 3) begin
      check("rng_addr_920",   32'(addr_q[0]), 920);
      check("rng_addr_921",   32'(addr_q[1]), 920);
      check("rng_addr_1023",  32'(addr_q[2]), 920);
      check("rng_tdata_920",  32'(beats[0].data), (32'd920 << CW) | 32'd920);
      check("rng_tuser_920",  32'(beats[0].user), 0);
      check("rng_tdata_921",  32'(beats[1].data), (32'd920 << CW) | 32'd921);
      check("rng_tuser_921",  32'(beats[1].user), 1);
      check("rng_tdata_1023", 32'(beats[2].data), (32'd920 << CW) | 32'd1023);
      check("rng_tuser_1023", 32'(beats[2].user), 1);
    end

    // tlast batch under low-2/high-6 sink pattern
    clear_logs();
    for (int i = 0; i < 5; i++) push_item(200 + i, (i == 4));
    run(40, 2);
    m_tready = 1'b1;
    check("tlast_beats", beats.size(), 5);
    check("tlast_stable", stab_bad, 0);
    if (beats.size() == 5) begin
      for (int j = 0; j < 5; j++) begin
        check($sformatf("tlast_flag_%0d", j), 32'(beats[j].last), (j == 4) ? 1 : 0);
        check($sformatf("tlast_tdata_%0d", j), 32'(beats[j].data), (32'(200 + j) << CW) | 32'(200 + j));
      end
    end

    // Reset with three items queued/in flight
    clear_logs();
    for (int i = 0; i < 3; i++) push_item(300 + i, 1'b0);
    run(3, 1);
    check("mid_accepted", acc_cyc_q.size(), 3);
    beats.delete();
    aresetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 32'(m_tvalid), 0);
    check("mid_rst_s_tready", 32'(s_tready), 0);
    tick();
    aresetn = 1'b1;
    src_q.delete();
    run(6, 0);
    check("mid_no_stale", beats.size(), 0);
    push_item(50, 1'b0);
    run(6, 0);
    check("mid_beats", beats.size(), 1);
    if (beats.size() == 1) begin
      check("mid_tdata", 32'(beats[0].data), (32'd50 << CW) | 32'd50);
      check("mid_tuser", 32'(beats[0].user), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
